// File: rtl/portgroup_txn.sv
// Multi-channel transmit core: per-channel pending flags, round-robin fill of a small FIFO,
// valid/ready output stream tagged with channel. Optional parity output under PORTGROUP_TXN_PARITY_EN.
module portgroup_txn #(
    parameter int width_p = 8,
    parameter int chan_p  = 4,
    parameter int depth_p = 4,
    localparam int CW     = (chan_p > 1) ? $clog2(chan_p) : 1,
    localparam int AW     = $clog2(depth_p),
    localparam int LW     = AW + 1
) (
    input  logic                      main_clk_i,
    input  logic                      main_rst_i,
    input  logic                      regf_ctrl_ena_rval_i,
    input  logic [chan_p*width_p-1:0] regf_tx_data_rval_i,
    input  logic [chan_p-1:0]         regf_tx_data_wr_i,
    input  logic                      regf_status_ovf_clr_i,
    output logic [chan_p-1:0]         regf_status_ovf_o,
    output logic                      regf_status_busy_o,
    output logic [LW-1:0]             regf_status_lvl_o,
    output logic                      tx_valid_o,
    input  logic                      tx_ready_i,
    output logic [width_p-1:0]        tx_data_o,
`ifdef PORTGROUP_TXN_PARITY_EN
    output logic                      tx_par_o,
`endif
    output logic [CW-1:0]             tx_chan_o
);

    // Stream handshake: an entry transfers on any clock edge where tx_valid_o and tx_ready_i
    // are both high; while tx_valid_o is high and tx_ready_i low the head entry is held stable.
`ifdef PORTGROUP_TXN_PARITY_EN
    localparam int EW = 1 + CW + width_p;
`else
    localparam int EW = CW + width_p;
`endif

    logic [chan_p-1:0]  pending_q, pending_d;
    logic [chan_p-1:0]  ovf_q, ovf_d;
    logic [CW-1:0]      rr_q, rr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      lvl_q, lvl_d;
    logic [EW-1:0]      mem_q [depth_p];

    logic               hi_vld, lo_vld;
    logic [CW-1:0]      hi_idx, lo_idx;
    logic [CW-1:0]      grant_idx;
    logic               grant;
    logic [chan_p-1:0]  grant_vec;
    logic [width_p-1:0] grant_data;
    logic [EW-1:0]      push_entry;
    logic [EW-1:0]      head;
    logic               pop;
    logic               can_push;

    assign head       = mem_q[rd_ptr_q];
    assign tx_valid_o = (lvl_q != '0);
    assign pop        = tx_valid_o & tx_ready_i;
    assign can_push   = (lvl_q != LW'(depth_p)) | pop;

    // Lowest pending channel at or above rr_q wins; otherwise wrap to the lowest pending overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int j = chan_p - 1; j >= 0; j--) begin
            if (pending_q[j]) begin
                lo_vld = 1'b1;
                lo_idx = CW'(j);
                if (CW'(j) >= rr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = CW'(j);
                end
            end
        end
    end

    assign grant_idx = hi_vld ? hi_idx : lo_idx;
    assign grant     = lo_vld & can_push & regf_ctrl_ena_rval_i;
    assign grant_vec = grant ? (chan_p'(1) << grant_idx) : '0;

    always_comb begin
        grant_data = '0;
        for (int j = 0; j < chan_p; j++) begin
            if (grant_idx == CW'(j)) begin
                grant_data = regf_tx_data_rval_i[j*width_p +: width_p];
            end
        end
    end

`ifdef PORTGROUP_TXN_PARITY_EN
    assign push_entry = {^grant_data, grant_idx, grant_data};
`else
    assign push_entry = {grant_idx, grant_data};
`endif

    always_comb begin
        pending_d = pending_q;
        rr_d      = rr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        lvl_d     = lvl_q;
        // A fresh overflow beats a simultaneous clear.
        ovf_d     = (ovf_q & ~{chan_p{regf_status_ovf_clr_i}})
                  | (regf_tx_data_wr_i & pending_q & ~grant_vec & {chan_p{regf_ctrl_ena_rval_i}});
        if (!regf_ctrl_ena_rval_i) begin
            pending_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            lvl_d     = '0;
        end else begin
            pending_d = (pending_q & ~grant_vec) | regf_tx_data_wr_i;
            if (grant) begin
                rr_d     = (grant_idx == CW'(chan_p - 1)) ? '0 : grant_idx + CW'(1);
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            lvl_d = lvl_q + LW'(grant) - LW'(pop);
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            pending_q <= '0;
            ovf_q     <= '0;
            rr_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lvl_q     <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            rr_q      <= rr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lvl_q     <= lvl_d;
        end
    end

    // Storage needs no reset: every read is qualified by a non-zero level.
    always_ff @(posedge main_clk_i) begin
        if (grant) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign tx_data_o          = tx_valid_o ? head[width_p-1:0] : '0;
    assign tx_chan_o          = tx_valid_o ? head[width_p +: CW] : '0;
`ifdef PORTGROUP_TXN_PARITY_EN
    assign tx_par_o           = tx_valid_o ? head[EW-1] : 1'b0;
`endif
    assign regf_status_ovf_o  = ovf_q;
    assign regf_status_lvl_o  = lvl_q;
    assign regf_status_busy_o = (|pending_q) | tx_valid_o;

endmodule

// File: tb/tb_portgroup_txn.sv
// Directed bench for portgroup_txn (width 8, 4 channels, depth 4) with an expected-stream queue.
module tb_portgroup_txn;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int CW = 2;
  localparam int LW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic [C*W-1:0] rval;
  logic [C-1:0]   wr;
  logic           ovf_clr;
  logic [C-1:0]   ovf;
  logic           busy;
  logic [LW-1:0]  lvl;
  logic           tx_valid;
  logic           tx_ready;
  logic [W-1:0]   tx_data;
  logic [CW-1:0]  tx_chan;
`ifdef PORTGROUP_TXN_PARITY_EN
  logic           tx_par;
`endif

  logic [CW+W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  portgroup_txn #(.width_p(W), .chan_p(C), .depth_p(D)) dut (
    .main_clk_i            (clk),
    .main_rst_i            (rst),
    .regf_ctrl_ena_rval_i  (ena),
    .regf_tx_data_rval_i   (rval),
    .regf_tx_data_wr_i     (wr),
    .regf_status_ovf_clr_i (ovf_clr),
    .regf_status_ovf_o     (ovf),
    .regf_status_busy_o    (busy),
    .regf_status_lvl_o     (lvl),
    .tx_valid_o            (tx_valid),
    .tx_ready_i            (tx_ready),
    .tx_data_o             (tx_data),
`ifdef PORTGROUP_TXN_PARITY_EN
    .tx_par_o              (tx_par),
`endif
    .tx_chan_o             (tx_chan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [C-1:0] m);
    wr = m;
    tick();
    wr = '0;
  endtask

  task automatic push_exp(input int ch, input logic [W-1:0] d);
    exp_q.push_back({CW'(ch), d});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Stream monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    logic [CW+W-1:0] e;
    if (!rst && tx_valid && tx_ready) begin
      chk("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_chan", tx_chan, e[W +: CW]);
        chk("tx_data", tx_data, e[W-1:0]);
`ifdef PORTGROUP_TXN_PARITY_EN
        chk("tx_par", tx_par, ^e[W-1:0]);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; rval = '0; wr = '0; ovf_clr = 1'b0; tx_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_chan", tx_chan, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lvl", lvl, 0);
    chk("rst_ovf", ovf, 0);

    // Single write: valid two cycles after the strobe
    ena = 1'b1; tx_ready = 1'b1;
    rval = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick();
    push_exp(2, 8'hA5);
    write(4'b0100);
    chk("single_t1_valid", tx_valid, 0);
    chk("single_t1_busy", busy, 1);
    tick();
    chk("single_t2_valid", tx_valid, 1);
    chk("single_t2_data", tx_data, 8'hA5);
    chk("single_t2_chan", tx_chan, 2);
    chk("single_t2_lvl", lvl, 1);
    tick();
    chk("single_done_lvl", lvl, 0);
    chk("single_done_busy", busy, 0);

    // Round-robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    rval = {8'h13, 8'h12, 8'h11, 8'h10};
    push_exp(0, 8'h10); push_exp(1, 8'h11); push_exp(2, 8'h12); push_exp(3, 8'h13);
    write(4'b1111);
    drain(20);
    rval = {8'h23, 8'h22, 8'h21, 8'h20};
    push_exp(0, 8'h20); push_exp(3, 8'h23);
    write(4'b1001);
    drain(20);

    // Full FIFO with backpressure; the fifth entry samples data at its grant
    tx_ready = 1'b0;
    rval = {8'h33, 8'h32, 8'h31, 8'h30};
    push_exp(0, 8'h30); write(4'b0001);
    push_exp(1, 8'h31); write(4'b0010);
    push_exp(2, 8'h32); write(4'b0100);
    push_exp(3, 8'h33); write(4'b1000);
    rval[15:8] = 8'h41;
    push_exp(1, 8'h41); write(4'b0010);
    tick(2);
    chk("full_lvl", lvl, 4);
    chk("full_busy", busy, 1);
    chk("full_valid", tx_valid, 1);
    chk("full_data", tx_data, 8'h30);
    chk("full_chan", tx_chan, 0);
    tick(3);
    chk("stall_data", tx_data, 8'h30);
    chk("stall_chan", tx_chan, 0);
    tx_ready = 1'b1;
    drain(20);
    chk("full_drained_lvl", lvl, 0);

    // Overflow while full, then clear and clear-vs-set race
    tx_ready = 1'b0;
    rval = {8'h53, 8'h52, 8'h51, 8'h50};
    push_exp(0, 8'h50); write(4'b0001);
    push_exp(2, 8'h52); write(4'b0100);
    push_exp(3, 8'h53); write(4'b1000);
    push_exp(0, 8'h50); write(4'b0001);
    push_exp(1, 8'h51); write(4'b0010);
    tick();
    chk("ovf_none_yet", ovf, 4'b0000);
    write(4'b0010);
    chk("ovf_set", ovf, 4'b0010);
    chk("ovf_full_lvl", lvl, 4);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 4'b0000);
    ovf_clr = 1'b1; wr = 4'b0010; tick(); ovf_clr = 1'b0; wr = '0;
    chk("ovf_set_wins", ovf, 4'b0010);
    tx_ready = 1'b1;
    drain(20);

    // Write landing on its own grant cycle is not an overflow
    push_exp(0, 8'h50); push_exp(0, 8'h50);
    write(4'b0001);
    write(4'b0001);
    drain(20);
    chk("grant_coincide_ovf", ovf, 4'b0010);

    // Enable drop flushes pending and FIFO, keeps ovf
    tx_ready = 1'b0;
    write(4'b0001); write(4'b0010); write(4'b0100);
    tick(2);
    chk("ena_pre_lvl", lvl, 3);
    ena = 1'b0;
    tick();
    chk("ena_off_valid", tx_valid, 0);
    chk("ena_off_lvl", lvl, 0);
    chk("ena_off_busy", busy, 0);
    chk("ena_off_ovf", ovf, 4'b0010);
    write(4'b1111);
    tick(3);
    chk("ena_off_wr_valid", tx_valid, 0);
    chk("ena_off_wr_busy", busy, 0);
    ena = 1'b1; tx_ready = 1'b1;
    tick(3);
    chk("ena_on_no_stale", tx_valid, 0);
    chk("ena_on_no_busy", busy, 0);

    // Reset while an entry is presented
    tx_ready = 1'b0;
    rval = {8'h00, 8'h07, 8'h00, 8'h00};
    write(4'b0100);
    tick();
    chk("mid_valid", tx_valid, 1);
    chk("mid_data", tx_data, 8'h07);
    chk("mid_chan", tx_chan, 2);
`ifdef PORTGROUP_TXN_PARITY_EN
    chk("mid_par", tx_par, 1);
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_valid", tx_valid, 0);
    chk("rst2_data", tx_data, 0);
    chk("rst2_chan", tx_chan, 0);
    chk("rst2_lvl", lvl, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_ovf", ovf, 0);
`ifdef PORTGROUP_TXN_PARITY_EN
    chk("rst2_par", tx_par, 0);
`endif
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
